// File: rtl/proc_multicycle.sv
// Multi-cycle MIPS-subset core: each instruction walks only the states it needs
// (IF/ID/EX[/MEM][/WB]), with a req/ack data port, halt, retire counter and LED tap.
module proc_multicycle #(
    parameter int          IA_W     = 11,
    parameter int          DA_W     = 11,
    parameter int          LED_REG  = 30,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            w_clk,
    input  logic            w_rst_n,
    output logic [IA_W-1:0] w_imem_addr,
    input  logic [31:0]     w_imem_data,
    output logic            w_dmem_req,
    output logic            w_dmem_we,
    output logic [DA_W-1:0] w_dmem_addr,
    output logic [31:0]     w_dmem_wdata,
    input  logic [31:0]     w_dmem_rdata,
    input  logic            w_dmem_ack,
    output logic [31:0]     r_led,
    output logic            w_halted,
    output logic [31:0]     r_icount
);

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3f;
    localparam logic [4:0] LED_IDX  = 5'(LED_REG);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_rf [32];
    logic [31:0] r_ir, r_a, r_b, r_imm, r_target, r_alu, r_mdr;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wb_dst;
    logic        w_is_rtype, w_is_addi, w_is_lw, w_is_sw;
    logic        w_is_beq, w_is_bne, w_is_j, w_is_halt;
    logic        w_ex_done, w_take, w_retire;
    logic [31:0] w_imm_sext, w_pc4, w_alu_res, w_wb_val, w_pc_nxt;

    function automatic logic [31:0] alu(input logic [5:0] funct,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (funct)
            6'h20:   alu = a + b;
            6'h22:   alu = a - b;
            6'h24:   alu = a & b;
            6'h25:   alu = a | b;
            6'h2a:   alu = {31'b0, (sa < sb)};
            6'h04:   alu = a << b[4:0];
            6'h06:   alu = a >> b[4:0];
            default: alu = 32'h0;
        endcase
    endfunction

    // IR stays valid from ID through WB, so decode is shared by all later states
    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_is_rtype = (w_op == OP_RTYPE) &&
                        (w_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h04, 6'h06});
    assign w_is_addi  = (w_op == OP_ADDI);
    assign w_is_lw    = (w_op == OP_LW);
    assign w_is_sw    = (w_op == OP_SW);
    assign w_is_beq   = (w_op == OP_BEQ);
    assign w_is_bne   = (w_op == OP_BNE);
    assign w_is_j     = (w_op == OP_J);
    assign w_is_halt  = (w_op == OP_HALT);

    assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_pc4      = r_pc + 32'd4;
    assign w_alu_res  = w_is_rtype ? alu(w_funct, r_a, r_b) : (r_a + r_imm);
    assign w_wb_dst   = w_is_rtype ? w_rd : w_rt;
    assign w_wb_val   = w_is_lw ? r_mdr : r_alu;
    assign w_take     = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b));
    assign w_ex_done  = !(w_is_lw || w_is_sw || w_is_rtype || w_is_addi);

    assign w_retire = ((r_state == S_EX) && w_ex_done) ||
                      ((r_state == S_MEM) && w_dmem_ack && w_is_sw) ||
                      (r_state == S_WB);

    always_comb begin
        w_pc_nxt = w_pc4;
        if (r_state == S_EX) begin
            if (w_take)
                w_pc_nxt = r_target;
            else if (w_is_j)
                w_pc_nxt = {w_pc4[31:28], r_ir[25:0], 2'b00};
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_state <= S_IF;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IF:   w_state_nxt = S_ID;
            S_ID:   w_state_nxt = w_is_halt ? S_HALT : S_EX;
            S_EX: begin
                if (w_is_lw || w_is_sw)
                    w_state_nxt = S_MEM;
                else if (w_is_rtype || w_is_addi)
                    w_state_nxt = S_WB;
                else
                    w_state_nxt = S_IF;
            end
            S_MEM: begin
                if (w_dmem_ack)
                    w_state_nxt = w_is_lw ? S_WB : S_IF;
            end
            S_WB:   w_state_nxt = S_IF;
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_IF;
        endcase
    end

    // Architectural state: PC, register file, LED tap, retire counter
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pc     <= RESET_PC;
            r_led    <= 32'h0;
            r_icount <= 32'h0;
            for (int i = 0; i < 32; i++)
                r_rf[i] <= 32'h0;
        end else begin
            if (w_retire) begin
                r_pc     <= w_pc_nxt;
                r_icount <= r_icount + 32'd1;
            end
            if ((r_state == S_WB) && (w_wb_dst != 5'd0)) begin
                r_rf[w_wb_dst] <= w_wb_val;
                if (w_wb_dst == LED_IDX)
                    r_led <= w_wb_val;
            end
        end
    end

    // Per-instruction scratch registers; only meaningful in the state that consumes them
    always_ff @(posedge w_clk) begin
        case (r_state)
            S_IF: r_ir <= w_imem_data;
            S_ID: begin
                r_a      <= r_rf[w_rs];
                r_b      <= r_rf[w_rt];
                r_imm    <= w_imm_sext;
                r_target <= w_pc4 + (w_imm_sext << 2);
            end
            S_EX: r_alu <= w_alu_res;
            S_MEM: begin
                if (w_dmem_ack)
                    r_mdr <= w_dmem_rdata;
            end
            default: ;
        endcase
    end

    assign w_imem_addr  = r_pc[IA_W+1:2];
    assign w_dmem_req   = (r_state == S_MEM);
    assign w_dmem_we    = w_dmem_req && w_is_sw;
    assign w_dmem_addr  = r_alu[DA_W+1:2];
    assign w_dmem_wdata = r_b;
    assign w_halted     = (r_state == S_HALT);

endmodule

// File: doc/proc_multicycle.md
Name: proc_multicycle

Overview:
Parametrised multi-cycle MIPS-subset processor, the next generation of the fixed 5-state core. It uses a variable-length state sequence, so each instruction runs only the phases it needs. It has an external data memory with a req/ack handshake, a halt instruction, a retired-instruction counter and an LED register tap. It sits between a program ROM and a data memory (or memory-mapped I/O) in simulation and FPGA tops.

Parameters:
IA_W, 11, instruction memory word-address width
DA_W, 11, data memory word-address width
LED_REG, 30, register number whose writes are mirrored to r_led
RESET_PC, 32'h0, PC value loaded on reset

Ports:
w_clk  in  1  clock, all state updates on posedge
w_rst_n  in  1  asynchronous active-low reset
w_imem_addr  out  IA_W  instruction word address = r_pc[IA_W+1:2]
w_imem_data  in  32  instruction, valid combinationally in the same cycle
w_dmem_req  out  1  data access request
w_dmem_we  out  1  1 = store, 0 = load; valid while req
w_dmem_addr  out  DA_W  word address = result[DA_W+1:2]
w_dmem_wdata  out  32  store data (rt value)
w_dmem_rdata  in  32  load data, valid in the ack cycle
w_dmem_ack  in  1  access complete, sampled only while req=1
r_led  out  32  last value written to LED_REG
w_halted  out  1  high in HALT state
r_icount  out  32  retired-instruction count

Behaviour:
- Reset (async, w_rst_n=0) sets: state IF, pc=RESET_PC, all 32 registers 0, r_led 0, r_icount 0, req 0, we 0, halted 0. Reset asserted mid-MEM drops req immediately.
- Register r0 always reads 0. Writes to r0 are discarded and never update r_led, even if LED_REG=0.
- Supported ops:
  - R-type funct 20 add, 22 sub, 24 and, 25 or, 2a slt (signed), 04 sllv (rs << rt[4:0]), 06 srlv (rs >> rt[4:0], logical).
  - op 08 addi (sign-extended imm), 23 lw, 2b sw, 04 beq, 05 bne, 02 j, 3f halt.
  - Any other encoding is a NOP.
- Arithmetic wraps mod 2^32. No overflow traps.
- States:
  - IF: latch w_imem_data into IR.
  - ID: decode, read rs/rt, sign-extend imm, compute branch target = pc+4+(sext(imm)<<2). halt goes to HALT (not counted). All other ops go to EX.
  - EX: ALU; lw/sw address = rs + sext(imm).
    - Branches/j/NOP: pc updated (taken: target; j: {pc+4[31:28], ir[25:0], 2'b00}; else pc+4), icount+1, go to IF.
    - lw/sw go to MEM. R-type/addi go to WB.
  - MEM: req=1 with addr/we/wdata held stable until a cycle with ack=1.
    - On that edge, lw latches rdata and goes to WB.
    - sw sets pc+4, icount+1, and goes to IF. req is deasserted the following cycle.
    - ack with req=0 is ignored.
  - WB: write dest (rd for R-type, rt for addi/lw). If dest==LED_REG and dest!=0, r_led gets the written value. pc+4, icount+1, go to IF.
  - HALT: absorbing; only reset exits. w_halted=1, no memory requests.
- Latencies (zero-wait memory, ack in first MEM cycle): branch/j/NOP 3 cycles, R-type/addi 4, sw 4, lw 5. Each wait cycle adds 1 to lw/sw.
- PC wraps mod 2^32. imem address uses only the low bits.
- Register written in WB is visible to the next instruction's ID (no forwarding needed, non-overlapping).
- r_icount wraps from FFFFFFFF to 0.

Test Plan:
- addi r30,r0,5; add r30,r30,r30 -> r_led 5, then 10; icount 2 after 8 cycles from reset release.
- sw r1 (=7) to addr 0x40, then lw r2 from 0x40, ack delayed 3 cycles each -> req held with addr 0x10 and stable wdata 7 for 3 cycles; r2=7; lw takes 8 cycles total.
- beq taken with imm=-1 (loop to self) vs bne not taken -> pc stays the same / pc advances by 4; each takes 3 cycles.
- sub 3-5 = FFFFFFFE; slt of (-1,1) = 1; sllv by 33 shifts by 1 -> matching results in r_led.
- Reset asserted during MEM wait -> req falls immediately; pc=RESET_PC, r_led=0, icount=0 after release.
- halt, then further ack pulses -> w_halted=1, pc and icount frozen, req stays 0.
